instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode bytes (and 2-byte JMP targets) from memory,
// issues them to the decoder, keeps the program counter in step and handles skips.
module instr_fetch (
   input  logic        pc_clk,
   input  logic        reset,
   input  logic [15:0] pc_addr,
   output logic [15:0] pc_next,
   output logic        pc_we,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        instr_valid,
   output logic [3:0]  instr_op,
   output logic [3:0]  instr_io,
   input  logic        dec_ready,
   input  logic        rr,
   output logic        flag_jmp,
   output logic        flag_rtn,
   output logic        flag_o,
   output logic        flag_f
);
   typedef enum logic [2:0] {SYNC, FETCH, ISSUE, JHI, JLO} state_t;

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_SKZ  = 4'hE;
   localparam logic [3:0] OP_NOPF = 4'hF;
   localparam logic [3:0] FLAG_OP [4] = '{OP_JMP, OP_RTN, OP_NOPO, OP_NOPF};

   state_t      state_reg, state_next;
   logic [15:0] fa_reg, fa_next;
   logic [15:0] pc_next_reg, pc_next_next;
   logic        pc_we_reg, pc_we_next;
   logic        skip_reg, skip_next;
   logic [3:0]  op_reg, op_next;
   logic [3:0]  io_reg, io_next;
   logic [7:0]  hi_reg, hi_next;
   logic        sync_reg, sync_next;
   logic        gap_reg, gap_next;
   logic [3:0]  flag_reg, flag_next;

   logic        ack_take;
   logic        xfer;
   logic [15:0] fa_inc;

   assign ack_take = mem_req && mem_ack;
   assign xfer     = (state_reg == ISSUE) && dec_ready;
   assign fa_inc   = fa_reg + 16'd1;

   // One flag bit per flagged opcode, pulsed the cycle after its transfer.
   for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign flag_next[gi] = xfer && (op_reg == FLAG_OP[gi]);
   end

   always_ff @(posedge pc_clk or posedge reset) begin
      if (reset) begin
         state_reg   <= SYNC;
         fa_reg      <= 16'h0000;
         pc_next_reg <= 16'h0000;
         pc_we_reg   <= 1'b0;
         skip_reg    <= 1'b0;
         op_reg      <= 4'h0;
         io_reg      <= 4'h0;
         hi_reg      <= 8'h00;
         sync_reg    <= 1'b0;
         gap_reg     <= 1'b0;
         flag_reg    <= 4'h0;
      end else begin
         state_reg   <= state_next;
         fa_reg      <= fa_next;
         pc_next_reg <= pc_next_next;
         pc_we_reg   <= pc_we_next;
         skip_reg    <= skip_next;
         op_reg      <= op_next;
         io_reg      <= io_next;
         hi_reg      <= hi_next;
         sync_reg    <= sync_next;
         gap_reg     <= gap_next;
         flag_reg    <= flag_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      fa_next      = fa_reg;
      pc_next_next = pc_next_reg;
      pc_we_next   = 1'b0;
      skip_next    = skip_reg;
      op_next      = op_reg;
      io_next      = io_reg;
      hi_next      = hi_reg;
      sync_next    = sync_reg;
      gap_next     = ack_take;
      case (state_reg)
         SYNC: begin
            // The PC already holds pc_addr, so this load is not echoed on pc_we.
            if (sync_reg) begin
               fa_next    = pc_addr;
               sync_next  = 1'b0;
               state_next = FETCH;
            end else begin
               sync_next  = 1'b1;
            end
         end
         FETCH: begin
            if (ack_take) begin
               fa_next      = fa_inc;
               pc_next_next = fa_inc;
               pc_we_next   = 1'b1;
               if (mem_rdata[7:4] == OP_JMP) begin
                  // A skipped JMP keeps skip_reg set so JLO drops the target.
                  if (!skip_reg) begin
                     op_next = mem_rdata[7:4];
                     io_next = mem_rdata[3:0];
                  end
                  state_next = JHI;
               end else if (skip_reg) begin
                  skip_next  = 1'b0;
               end else begin
                  op_next    = mem_rdata[7:4];
                  io_next    = mem_rdata[3:0];
                  state_next = ISSUE;
               end
            end
         end
         JHI: begin
            if (ack_take) begin
               hi_next      = mem_rdata;
               fa_next      = fa_inc;
               pc_next_next = fa_inc;
               pc_we_next   = 1'b1;
               state_next   = JLO;
            end
         end
         JLO: begin
            if (ack_take) begin
               pc_we_next = 1'b1;
               if (skip_reg) begin
                  fa_next      = fa_inc;
                  pc_next_next = fa_inc;
                  skip_next    = 1'b0;
                  state_next   = FETCH;
               end else begin
                  fa_next      = {hi_reg, mem_rdata};
                  pc_next_next = {hi_reg, mem_rdata};
                  state_next   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (dec_ready) begin
               state_next = FETCH;
               if (op_reg == OP_RTN || (op_reg == OP_SKZ && !rr)) begin
                  skip_next = 1'b1;
               end
            end
         end
         default: state_next = SYNC;
      endcase
   end

   // gap_reg drops the request for one cycle after every accepted read.
   assign mem_req     = (state_reg == FETCH || state_reg == JHI || state_reg == JLO) && !gap_reg;
   assign mem_addr    = fa_reg;
   assign pc_next     = pc_next_reg;
   assign pc_we       = pc_we_reg;
   assign instr_valid = (state_reg == ISSUE);
   assign instr_op    = op_reg;
   assign instr_io    = io_reg;
   assign flag_jmp    = flag_reg[0];
   assign flag_rtn    = flag_reg[1];
   assign flag_o      = flag_reg[2];
   assign flag_f      = flag_reg[3];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, byte-stream interpreter model checked every
// cycle, directed programs with literal expectations, then randomized programs.
module tb_instr_fetch;
   logic        pc_clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc_addr = 16'h0000;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic        dec_ready = 1'b0;
   logic        rr = 1'b0;
   logic [15:0] pc_next, mem_addr;
   logic        pc_we, mem_req, instr_valid;
   logic [3:0]  instr_op, instr_io;
   logic        flag_jmp, flag_rtn, flag_o, flag_f;
   logic [3:0]  dut_flags;

   instr_fetch dut (
      .pc_clk(pc_clk), .reset(reset), .pc_addr(pc_addr), .pc_next(pc_next), .pc_we(pc_we),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_op(instr_op), .instr_io(instr_io),
      .dec_ready(dec_ready), .rr(rr), .flag_jmp(flag_jmp), .flag_rtn(flag_rtn),
      .flag_o(flag_o), .flag_f(flag_f)
   );

   always #5 pc_clk = ~pc_clk;
   assign dut_flags = {flag_f, flag_o, flag_rtn, flag_jmp};

   logic [7:0] mem [65536];
   int n_checks = 0;
   int n_fails = 0;

   // stimulus knobs
   int lat_mode = 0;     // <0: random latency 0..3
   int ready_mode = 1;   // 0 low, 1 high, 2 random
   int rr_mode = 1;      // 0 low, 1 high, 2 random
   int wait_cnt = -1;
   bit rel_req = 1'b0;

   // reference model: interprets the byte stream the unit reads
   int          m_sync;
   bit          m_first, m_pend, m_skip, m_jskip, exp_we;
   int          m_phase;
   logic [15:0] m_fa, exp_pcn;
   logic [3:0]  m_op, m_io, exp_flags;
   logic [7:0]  m_hi;

   // observation logs, cleared at each reset
   logic [15:0] rd_log[$];
   logic [15:0] we_log[$];
   logic [7:0]  xf_log[$];
   int cnt_jmp, cnt_rtn, cnt_o, cnt_f;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      if (rel_req) begin
         reset = 1'b0;
         rel_req = 1'b0;
      end
      mem_ack = 1'b0;
      if (!reset && mem_req) begin
         if (wait_cnt < 0) wait_cnt = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
         if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            wait_cnt = -1;
         end else begin
            wait_cnt--;
         end
      end else begin
         wait_cnt = -1;
         if ($urandom_range(7, 0) == 0) begin
            mem_ack = 1'b1;
            mem_rdata = 8'($urandom);
         end
      end
      dec_ready = (ready_mode == 2) ? 1'($urandom_range(1, 0)) : (ready_mode == 1);
      rr = (rr_mode == 2) ? 1'($urandom_range(1, 0)) : (rr_mode == 1);
   endtask

   task automatic compare_step();
      logic [7:0] b;
      if (reset) begin
         check("reset_ctrl", {mem_req, instr_valid, pc_we, dut_flags, instr_op, instr_io}, 64'd0);
         check("reset_addr", {pc_next, mem_addr}, 64'd0);
         m_sync = 0; m_first = 0; m_pend = 0; m_skip = 0; m_jskip = 0;
         m_phase = 0; exp_we = 0; exp_flags = 4'h0;
         return;
      end
      if (m_sync < 2) begin
         check("sync_quiet", {mem_req, instr_valid, pc_we, dut_flags}, 64'd0);
         m_sync++;
         if (m_sync == 2) begin
            m_fa = pc_addr;
            m_first = 1'b1;
         end
         return;
      end
      if (m_first) begin
         check("sync_len_req", mem_req, 1);
         m_first = 1'b0;
      end
      check("pc_we", pc_we, exp_we);
      if (exp_we) check("pc_next", pc_next, exp_pcn);
      check("flags", dut_flags, exp_flags);
      check("instr_valid", instr_valid, m_pend);
      if (m_pend) check("instr_opio", {instr_op, instr_io}, {m_op, m_io});
      if (instr_valid) check("req_in_issue", mem_req, 0);
      if (mem_req) check("mem_addr", mem_addr, m_fa);

      if (pc_we) we_log.push_back(pc_next);
      cnt_jmp += int'(flag_jmp); cnt_rtn += int'(flag_rtn);
      cnt_o += int'(flag_o); cnt_f += int'(flag_f);
      exp_we = 1'b0;
      exp_flags = 4'h0;

      if (m_pend && dec_ready) begin
         xf_log.push_back({instr_op, instr_io});
         $display("xfer op=%h io=%h rr=%0d", instr_op, instr_io, rr);
         case (m_op)
            4'hC: exp_flags = 4'b0001;
            4'hD: exp_flags = 4'b0010;
            4'h0: exp_flags = 4'b0100;
            4'hF: exp_flags = 4'b1000;
            default: exp_flags = 4'b0000;
         endcase
         if (m_op == 4'hD || (m_op == 4'hE && !rr)) m_skip = 1'b1;
         m_pend = 1'b0;
      end
      if (mem_req && mem_ack) begin
         rd_log.push_back(mem_addr);
         b = mem[m_fa];
         if (m_phase == 0) begin
            m_fa = m_fa + 16'd1;
            exp_we = 1'b1; exp_pcn = m_fa;
            if (b[7:4] == 4'hC) begin
               m_jskip = m_skip; m_skip = 1'b0;
               m_op = b[7:4]; m_io = b[3:0];
               m_phase = 1;
            end else if (m_skip) begin
               m_skip = 1'b0;
            end else begin
               m_pend = 1'b1; m_op = b[7:4]; m_io = b[3:0];
            end
         end else if (m_phase == 1) begin
            m_hi = b;
            m_fa = m_fa + 16'd1;
            exp_we = 1'b1; exp_pcn = m_fa;
            m_phase = 2;
         end else begin
            if (m_jskip) m_fa = m_fa + 16'd1;
            else begin
               m_fa = {m_hi, b};
               m_pend = 1'b1;
            end
            m_jskip = 1'b0;
            exp_we = 1'b1; exp_pcn = m_fa;
            m_phase = 0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge pc_clk);
      #1;
      drive();
      @(negedge pc_clk);
      compare_step();
   endtask

   task automatic do_reset(input logic [15:0] pc);
      reset = 1'b1;
      pc_addr = pc;
      rd_log.delete(); we_log.delete(); xf_log.delete();
      cnt_jmp = 0; cnt_rtn = 0; cnt_o = 0; cnt_f = 0;
      repeat (2) cycle();
      rel_req = 1'b1;
   endtask

   task automatic run_until_xfers(input int n, input int budget);
      int k = 0;
      while (xf_log.size() < n && k < budget) begin
         cycle();
         k++;
      end
      check("xfer_timeout", xf_log.size() >= n, 1);
      repeat (2) cycle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h9A;

      // plain fetch, ack after 2 cycles
      mem[16'h0100] = 8'h12;
      lat_mode = 2; ready_mode = 1; rr_mode = 1;
      do_reset(16'h0100);
      run_until_xfers(1, 60);
      check("t1_addr", rd_log[0], 16'h0100);
      check("t1_issue", xf_log[0], 8'h12);
      check("t1_pcnext", we_log[0], 16'h0101);

      // JMP with 2-byte target
      mem[16'h0200] = 8'hC7; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h56;
      mem[16'h3456] = 8'h1A;
      lat_mode = -1;
      do_reset(16'h0200);
      run_until_xfers(2, 100);
      check("t2_reads", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 64'h0200_0201_0202_3456);
      check("t2_we", {we_log[0], we_log[1], we_log[2]}, 64'h0201_0202_3456);
      check("t2_issue", {xf_log[0], xf_log[1]}, 16'hC71A);
      check("t2_flag_jmp", cnt_jmp, 1);

      // SKZ with rr=0 skips the next instruction, rr=1 does not
      mem[16'h0300] = 8'hE0; mem[16'h0301] = 8'h15; mem[16'h0302] = 8'h27;
      rr_mode = 0;
      do_reset(16'h0300);
      run_until_xfers(2, 100);
      check("t3_issue", {xf_log[0], xf_log[1]}, 16'hE027);
      check("t3_we", {we_log[0], we_log[1], we_log[2]}, 64'h0301_0302_0303);
      rr_mode = 1;
      do_reset(16'h0300);
      run_until_xfers(3, 100);
      check("t4_issue", {xf_log[0], xf_log[1], xf_log[2]}, 24'hE01527);

      // address wrap
      mem[16'hFFFF] = 8'h3B; mem[16'h0000] = 8'h4C;
      do_reset(16'hFFFF);
      run_until_xfers(2, 100);
      check("t5_wrap", {rd_log[0], we_log[0], rd_log[1]}, 64'hFFFF_0000_0000);
      check("t5_issue", {xf_log[0], xf_log[1]}, 16'h3B4C);

      // RTN skips a whole JMP (3 bytes, no target load)
      mem[16'h0600] = 8'hD0; mem[16'h0601] = 8'hC1; mem[16'h0602] = 8'h77;
      mem[16'h0603] = 8'h88; mem[16'h0604] = 8'h3A;
      do_reset(16'h0600);
      run_until_xfers(2, 100);
      check("t8_issue", {xf_log[0], xf_log[1]}, 16'hD03A);
      check("t8_reads", {rd_log[1], rd_log[3], rd_log[4]}, 48'h0601_0603_0604);
      check("t8_flags", {cnt_rtn[7:0], cnt_jmp[7:0]}, 16'h0100);

      // RTN then SKZ(rr=0): the SKZ is skipped and arms nothing
      mem[16'h0700] = 8'hD5; mem[16'h0701] = 8'hE0; mem[16'h0702] = 8'h21;
      rr_mode = 0;
      do_reset(16'h0700);
      run_until_xfers(2, 100);
      check("t9_issue", {xf_log[0], xf_log[1]}, 16'hD521);
      check("t9_we", {we_log[0], we_log[1], we_log[2]}, 64'h0701_0702_0703);

      // NOPO and NOPF flags
      mem[16'h0800] = 8'h03; mem[16'h0801] = 8'hF4;
      do_reset(16'h0800);
      run_until_xfers(2, 100);
      check("t10_flags", {cnt_o[7:0], cnt_f[7:0]}, 16'h0101);

      // decoder stall for 5 cycles
      mem[16'h0900] = 8'h59;
      ready_mode = 0; lat_mode = 0;
      do_reset(16'h0900);
      for (int k = 0; k < 40 && !instr_valid; k++) cycle();
      check("t6_valid_seen", instr_valid, 1);
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("t6_hold", {instr_valid, instr_op, instr_io, mem_req}, {1'b1, 8'h59, 1'b0});
      end
      check("t6_no_xfer", xf_log.size(), 0);
      ready_mode = 1;
      repeat (2) cycle();
      check("t6_one_xfer", xf_log.size(), 1);

      // reset during a pending read; late ack ignored
      lat_mode = 1000;
      do_reset(16'h0A00);
      for (int k = 0; k < 20 && !mem_req; k++) cycle();
      check("t7_req_seen", mem_req, 1);
      @(posedge pc_clk);
      #1;
      reset = 1'b1;
      mem_ack = 1'b1;
      #1;
      check("t7_req_drop", mem_req, 0);
      @(negedge pc_clk);
      compare_step();
      mem[16'h0A00] = 8'h66;
      lat_mode = 1;
      do_reset(16'h0A00);
      run_until_xfers(1, 60);
      check("t7_refetch", {rd_log[0], 8'(xf_log[0])}, 24'h0A0066);

      // randomized programs
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      lat_mode = -1; ready_mode = 2; rr_mode = 2;
      for (int r = 0; r < 4; r++) begin
         do_reset(16'($urandom));
         repeat (1500 + $urandom_range(500, 0)) cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
